branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 27 ++
 rtl/branch_predictor_sat_counter2.sv | 18 +
 rtl/branch_predictor.sv | 149 ++++++++++++++
 tb/tb_branch_predictor.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and defaults for the branch predictor slice.
package CorePack;

  localparam int unsigned ADDR_W       = 64;
  localparam int unsigned BP_BHT_IDX_W = 6;
  localparam int unsigned BP_TAG_W     = 8;
  // Widest tag an entry can carry; narrower tags are zero-extended into it.
  localparam int unsigned TAG_W_MAX    = 32;

  localparam logic [1:0] CNT_RESET = 2'b01;
  localparam logic [1:0] CNT_ALLOC = 2'b10;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [1:0]           cnt;
    addr_t                target;
  } bht_entry_t;

  // 32-bit event counter increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter, purely combinational next state.
module sat_counter2 (
  input  logic [1:0] cnt_i,
  input  logic       up_i,
  output logic [1:0] cnt_o
);

  // Step towards 2'b11 when up, towards 2'b00 otherwise, holding at the ends.
  always_comb begin
    cnt_o = cnt_i;
    if (up_i) begin
      if (cnt_i != 2'b11) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != 2'b00) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Tagged BHT/BTB branch predictor with registered mispredict redirect
// and saturating resolved-branch / mispredict counters.
module branch_predictor
  import CorePack::*;
#(
  parameter int unsigned BHT_IDX_W = BP_BHT_IDX_W,
  parameter int unsigned TAG_W     = BP_TAG_W
) (
  input  logic        clk,
  input  logic        rstn,
  input  addr_t       if_pc,
  output logic        pred_taken,
  output addr_t       pred_target,
  input  logic        ex_valid,
  input  addr_t       ex_pc,
  input  logic        ex_taken,
  input  addr_t       ex_target,
  input  logic        ex_pred_taken,
  input  addr_t       ex_pred_target,
  output logic        redirect_valid,
  output addr_t       redirect_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int unsigned DEPTH = 1 << BHT_IDX_W;

  logic [BHT_IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]     if_tag, ex_tag;

  logic                 valid_q  [DEPTH];
  logic                 valid_d  [DEPTH];
  logic [1:0]           cnt_q    [DEPTH];
  logic [1:0]           cnt_d    [DEPTH];
  logic [TAG_W-1:0]     tag_q    [DEPTH];
  logic [TAG_W-1:0]     tag_d    [DEPTH];
  addr_t                target_q [DEPTH];
  addr_t                target_d [DEPTH];

  bht_entry_t           if_entry;
  logic                 if_hit;
  logic                 unused_if_cnt_lsb;

  logic                 ex_hit;
  logic [1:0]           ex_cnt_next;
  logic                 mispredict;

  logic                 redirect_valid_q, redirect_valid_d;
  addr_t                redirect_pc_q, redirect_pc_d;
  logic [31:0]          br_cnt_q, br_cnt_d;
  logic [31:0]          mispred_cnt_q, mispred_cnt_d;

  assign if_idx = if_pc[BHT_IDX_W+1:2];
  assign if_tag = if_pc[TAG_W+BHT_IDX_W+1:BHT_IDX_W+2];
  assign ex_idx = ex_pc[BHT_IDX_W+1:2];
  assign ex_tag = ex_pc[TAG_W+BHT_IDX_W+1:BHT_IDX_W+2];

  // Fetch-side lookup from registered state only; a same-cycle EX write is not bypassed.
  always_comb begin
    if_entry.valid  = valid_q[if_idx];
    if_entry.tag    = TAG_W_MAX'(tag_q[if_idx]);
    if_entry.cnt    = cnt_q[if_idx];
    if_entry.target = target_q[if_idx];
    if_hit          = if_entry.valid && (if_entry.tag == TAG_W_MAX'(if_tag));
    pred_taken      = if_hit && if_entry.cnt[1];
    pred_target     = pred_taken ? if_entry.target : if_pc + 64'd4;
  end

  assign unused_if_cnt_lsb = if_entry.cnt[0];

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  sat_counter2 u_sat_counter2 (
    .cnt_i (cnt_q[ex_idx]),
    .up_i  (ex_taken),
    .cnt_o (ex_cnt_next)
  );

  // Table update from the resolved branch: train on hit, allocate on taken miss.
  always_comb begin
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (ex_valid) begin
      if (ex_hit) begin
        cnt_d[ex_idx] = ex_cnt_next;
        if (ex_taken) target_d[ex_idx] = ex_target;
      end else if (ex_taken) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        cnt_d[ex_idx]    = CNT_ALLOC;
        target_d[ex_idx] = ex_target;
      end
    end
  end

  // Mispredict detection, redirect target and event counters.
  always_comb begin
    mispredict = ex_valid &&
                 ((ex_taken != ex_pred_taken) ||
                  (ex_taken && (ex_target != ex_pred_target)));
    redirect_valid_d = mispredict;
    redirect_pc_d    = '0;
    if (mispredict) redirect_pc_d = ex_taken ? ex_target : ex_pc + 64'd4;
    br_cnt_d      = ex_valid   ? sat_inc32(br_cnt_q)      : br_cnt_q;
    mispred_cnt_d = mispredict ? sat_inc32(mispred_cnt_q) : mispred_cnt_q;
  end

  // Valid bits and counters are the only table state that needs reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_RESET;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tag and target storage, left unreset since valid gates every use.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  // Redirect and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      br_cnt_q         <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      br_cnt_q         <= br_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign br_cnt         = br_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic, all compared against a behavioural table model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [63:0] if_pc = '0;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        ex_valid = 1'b0;
  logic [63:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [63:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [63:0] ex_pred_target = '0;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  int n_total = 0;
  int n_bad   = 0;

  branch_predictor #(.BHT_IDX_W(6), .TAG_W(8)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .br_cnt         (br_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: 64 entries, tag = pc/256 mod 256, strength 0..3.
  bit          m_v [64];
  int          m_t [64];
  int          m_c [64];
  logic [63:0] m_g [64];
  bit          exp_rv  = 1'b0;
  logic [63:0] exp_rpc = '0;
  longint      exp_br  = 0;
  longint      exp_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int m_idx(input logic [63:0] pc);
    logic [63:0] t;
    t = (pc / 4) % 64;
    return int'(t);
  endfunction

  function automatic int m_tag(input logic [63:0] pc);
    logic [63:0] t;
    t = (pc / 256) % 256;
    return int'(t);
  endfunction

  function automatic bit m_hit(input logic [63:0] pc);
    return m_v[m_idx(pc)] && (m_t[m_idx(pc)] == m_tag(pc));
  endfunction

  function automatic bit m_ptaken(input logic [63:0] pc);
    return m_hit(pc) && (m_c[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [63:0] m_ptarget(input logic [63:0] pc);
    return m_ptaken(pc) ? m_g[m_idx(pc)] : pc + 64'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_v[i] = 1'b0;
      m_c[i] = 1;
    end
    exp_rv = 1'b0; exp_rpc = '0; exp_br = 0; exp_mis = 0;
  endtask

  task automatic model_update();
    bit mis;
    int i;
    exp_rv = 1'b0;
    exp_rpc = '0;
    if (ex_valid) begin
      if (exp_br < 64'hFFFF_FFFF) exp_br++;
      mis = (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target);
      if (mis) begin
        if (exp_mis < 64'hFFFF_FFFF) exp_mis++;
        exp_rv  = 1'b1;
        exp_rpc = ex_taken ? ex_target : ex_pc + 64'd4;
      end
      i = m_idx(ex_pc);
      if (m_hit(ex_pc)) begin
        m_c[i] = ex_taken ? ((m_c[i] < 3) ? m_c[i] + 1 : 3) : ((m_c[i] > 0) ? m_c[i] - 1 : 0);
        if (ex_taken) m_g[i] = ex_target;
      end else if (ex_taken) begin
        m_v[i] = 1'b1;
        m_t[i] = m_tag(ex_pc);
        m_c[i] = 2;
        m_g[i] = ex_target;
      end
    end
  endtask

  // Entered just after a falling edge with inputs applied; leaves at the next falling edge.
  task automatic run_cycle();
    #1;
    check("pred_taken", {63'd0, pred_taken}, {63'd0, m_ptaken(if_pc)});
    check("pred_target", pred_target, m_ptarget(if_pc));
    @(posedge clk);
    model_update();
    #1;
    check("redirect_valid", {63'd0, redirect_valid}, {63'd0, exp_rv});
    if (exp_rv) check("redirect_pc", redirect_pc, exp_rpc);
    check("br_cnt", {32'd0, br_cnt}, exp_br);
    check("mispred_cnt", {32'd0, mispred_cnt}, exp_mis);
    @(negedge clk);
  endtask

  // Resolve a branch whose carried prediction is what the model would have predicted.
  task automatic resolve(input logic [63:0] pc, input bit taken, input logic [63:0] tgt);
    ex_valid = 1'b1; ex_pc = pc; ex_taken = taken; ex_target = tgt;
    ex_pred_taken = m_ptaken(pc); ex_pred_target = m_ptarget(pc);
    run_cycle();
    ex_valid = 1'b0;
  endtask

  function automatic logic [63:0] rnd_pc();
    return 64'h4000 + 64'(($urandom % 3) * 256) + 64'(($urandom % 8) * 4);
  endfunction

  initial begin
    model_reset();
    #1 rstn = 1'b0;
    if_pc = 64'h1000;
    #1;
    check("rst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    check("rst_redirect_pc", redirect_pc, 64'd0);
    check("rst_br_cnt", {32'd0, br_cnt}, 64'd0);
    check("rst_mispred_cnt", {32'd0, mispred_cnt}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Cold prediction
    if_pc = 64'h1000;
    #1;
    check("cold_pred_taken", {63'd0, pred_taken}, 64'd0);
    check("cold_pred_target", pred_target, 64'h1004);
    check("cold_br_cnt", {32'd0, br_cnt}, 64'd0);

    // First taken resolve: mispredict, allocate
    ex_valid = 1'b1; ex_pc = 64'h1000; ex_taken = 1'b1; ex_target = 64'h2000;
    ex_pred_taken = 1'b0; ex_pred_target = 64'h1004;
    run_cycle();
    ex_valid = 1'b0;
    check("alloc_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    check("alloc_redirect_pc", redirect_pc, 64'h2000);
    #1;
    check("alloc_pred_taken", {63'd0, pred_taken}, 64'd1);
    check("alloc_pred_target", pred_target, 64'h2000);
    check("alloc_mispred_cnt", {32'd0, mispred_cnt}, 64'd1);

    // Saturate, then walk back down
    for (int k = 0; k < 3; k++) resolve(64'h1000, 1'b1, 64'h2000);
    resolve(64'h1000, 1'b0, 64'h2000);
    #1 check("sat_nt1_pred_taken", {63'd0, pred_taken}, 64'd1);
    resolve(64'h1000, 1'b0, 64'h2000);
    #1 check("sat_nt2_pred_taken", {63'd0, pred_taken}, 64'd0);
    resolve(64'h1000, 1'b1, 64'h2000);

    // Same-cycle read of the index being updated sees old state
    ex_valid = 1'b1; ex_pc = 64'h1000; ex_taken = 1'b0; ex_target = 64'h2000;
    ex_pred_taken = m_ptaken(64'h1000); ex_pred_target = m_ptarget(64'h1000);
    #1 check("same_cycle_old", {63'd0, pred_taken}, 64'd1);
    run_cycle();
    ex_valid = 1'b0;
    #1 check("same_cycle_new", {63'd0, pred_taken}, 64'd0);

    // Aliasing replaces the entry
    resolve(64'h1000, 1'b1, 64'h2000);
    resolve(64'h1000 + (64'd4 << 6), 1'b1, 64'h3000);
    if_pc = 64'h1000;
    #1 check("alias_pred_taken", {63'd0, pred_taken}, 64'd0);
    if_pc = 64'h1100;
    #1 check("alias_new_pred_taken", {63'd0, pred_taken}, 64'd1);

    // Reset in the cycle after a mispredict
    ex_valid = 1'b1; ex_pc = 64'h3000; ex_taken = 1'b1; ex_target = 64'h5000;
    ex_pred_taken = 1'b0; ex_pred_target = 64'h3004;
    @(posedge clk);
    model_update();
    #1 check("pre_rst_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    ex_valid = 1'b0;
    rstn = 1'b0;
    model_reset();
    #1;
    check("mid_rst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    check("mid_rst_br_cnt", {32'd0, br_cnt}, 64'd0);
    if_pc = 64'h1100;
    #1 check("mid_rst_pred_1100", {63'd0, pred_taken}, 64'd0);
    if_pc = 64'h3000;
    #1 check("mid_rst_pred_3000", {63'd0, pred_taken}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if_pc     = rnd_pc();
      ex_valid  = ($urandom % 4) != 0;
      ex_pc     = rnd_pc();
      ex_taken  = $urandom % 2;
      ex_target = 64'h8000 + 64'(($urandom % 4) * 16);
      if (($urandom % 5) == 0) begin
        ex_pred_taken  = $urandom % 2;
        ex_pred_target = 64'h8000 + 64'(($urandom % 4) * 16);
      end else begin
        ex_pred_taken  = m_ptaken(ex_pc);
        ex_pred_target = m_ptarget(ex_pc);
      end
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
